// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
package serializer_pkg;

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int MIN_MOD = 3;

  // Maps the requested bit count to a transfer length; 0 marks an illegal request.
  function automatic int mod_to_len(input int mod, input int width);
    if (mod == 0) begin
      return width;
    end else if (mod < MIN_MOD) begin
      return 0;
    end else begin
      return mod;
    end
  endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter: latches a word and shifts N bits out MSB first,
// with registered serial data, valid strobe and busy flag.
module serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MOD_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [MOD_W-1:0] data_mod_i,
  input  logic             data_val_i,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ser_next, val_next;
  int               len;

  // The counter holds the bits still to be shown, including the one on the output now.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    cnt_next   = cnt;
    ser_next   = 1'b0;
    val_next   = 1'b0;
    len        = mod_to_len(int'(data_mod_i), WIDTH);

    case (state)
      IDLE: begin
        if (data_val_i && (len != 0)) begin
          state_next = SHIFT;
          ser_next   = data_i[WIDTH-1];
          val_next   = 1'b1;
          shift_next = {data_i[WIDTH-2:0], 1'b0};
          cnt_next   = CNT_W'(len);
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(1)) begin
          state_next = IDLE;
          shift_next = '0;
          cnt_next   = '0;
        end else begin
          ser_next   = shift_reg[WIDTH-1];
          val_next   = 1'b1;
          shift_next = {shift_reg[WIDTH-2:0], 1'b0};
          cnt_next   = cnt - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state          <= IDLE;
      shift_reg      <= '0;
      cnt            <= '0;
      ser_data_o     <= 1'b0;
      ser_data_val_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state          <= state_next;
      shift_reg      <= shift_next;
      cnt            <= cnt_next;
      ser_data_o     <= ser_next;
      ser_data_val_o <= val_next;
      busy_o         <= val_next;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: directed and random requests compared
// cycle by cycle against a queue-of-pending-bits reference model.
module tb_serializer;

  localparam int WIDTH = 16;
  localparam int MOD_W = 4;

  logic             clk_i = 1'b0;
  logic             srst_i;
  logic [WIDTH-1:0] data_i;
  logic [MOD_W-1:0] data_mod_i;
  logic             data_val_i;
  logic             ser_data_o;
  logic             ser_data_val_o;
  logic             busy_o;

  int          checks = 0;
  int          failures = 0;
  bit          model_q[$];
  logic [31:0] rx_word;
  int          rx_cnt;

  serializer #(.WIDTH(WIDTH), .MOD_W(MOD_W)) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .data_i         (data_i),
    .data_mod_i     (data_mod_i),
    .data_val_i     (data_val_i),
    .ser_data_o     (ser_data_o),
    .ser_data_val_o (ser_data_val_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int specLen(input logic [MOD_W-1:0] mod);
    if (mod == 0) return WIDTH;
    if (mod < 3) return 0;
    return int'(mod);
  endfunction

  // Reference behaviour: pending bits form a queue; the output shows its head.
  task automatic modelEdge(input logic rst, input logic val, input logic [WIDTH-1:0] data,
                           input logic [MOD_W-1:0] mod);
    int n;
    if (rst) begin
      model_q.delete();
    end else if (model_q.size() > 0) begin
      void'(model_q.pop_front());
    end else if (val) begin
      n = specLen(mod);
      for (int i = 0; i < n; i++) model_q.push_back(data[WIDTH-1-i]);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic exp_val, exp_ser;
    exp_val = (model_q.size() > 0);
    exp_ser = exp_val ? model_q[0] : 1'b0;
    checks++;
    assert (ser_data_val_o === exp_val) else begin
      failures++;
      $error("[TB] FAIL %s ser_data_val_o observed=%0b expected=%0b", tag, ser_data_val_o, exp_val);
    end
    checks++;
    assert (busy_o === exp_val) else begin
      failures++;
      $error("[TB] FAIL %s busy_o observed=%0b expected=%0b", tag, busy_o, exp_val);
    end
    checks++;
    assert (ser_data_o === exp_ser) else begin
      failures++;
      $error("[TB] FAIL %s ser_data_o observed=%0b expected=%0b", tag, ser_data_o, exp_ser);
    end
    if (ser_data_val_o === 1'b1) begin
      rx_word = {rx_word[30:0], ser_data_o};
      rx_cnt++;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic val, input logic [WIDTH-1:0] data,
                               input logic [MOD_W-1:0] mod, input string tag);
    srst_i     = rst;
    data_val_i = val;
    data_i     = data;
    data_mod_i = mod;
    @(posedge clk_i);
    modelEdge(rst, val, data, mod);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, WIDTH'($urandom), MOD_W'($urandom), tag);
  endtask

  task automatic clearRx();
    rx_word = '0;
    rx_cnt  = 0;
  endtask

  task automatic checkWord(input string tag, input logic [31:0] exp_word, input int exp_cnt);
    checks++;
    assert (rx_cnt == exp_cnt && rx_word === exp_word) else begin
      failures++;
      $error("[TB] FAIL %s received=%0h/%0d bits expected=%0h/%0d bits",
             tag, rx_word, rx_cnt, exp_word, exp_cnt);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    logic [MOD_W-1:0] m;
    int               n;

    srst_i = 1'b1; data_val_i = 1'b0; data_i = '0; data_mod_i = '0;
    clearRx();

    applyStimulus(1'b1, 1'b1, 16'hFFFF, 4'd0, "reset");
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'd0, "reset");

    clearRx();
    applyStimulus(1'b0, 1'b1, 16'hA5C3, 4'd0, "full_word");
    idleCycles(18, "full_word");
    checkWord("full_word_bits", 32'h0000A5C3, 16);

    clearRx();
    applyStimulus(1'b0, 1'b1, 16'hF800, 4'd5, "mod5");
    idleCycles(8, "mod5");
    checkWord("mod5_bits", 32'h0000001F, 5);

    clearRx();
    applyStimulus(1'b0, 1'b1, 16'hBEEF, 4'd1, "illegal1");
    applyStimulus(1'b0, 1'b1, 16'h1234, 4'd2, "illegal2");
    idleCycles(20, "illegal_idle");
    checkWord("illegal_bits", 32'h0, 0);
    w = WIDTH'($urandom);
    applyStimulus(1'b0, 1'b1, w, 4'd0, "after_illegal");
    idleCycles(17, "after_illegal");
    checkWord("after_illegal_bits", 32'(w), 16);

    clearRx();
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 4'd0, "busy_ignore");
    idleCycles(4, "busy_ignore");
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b0, 1'b1, 16'h0000, 4'd3, "held_valid");
    idleCycles(3, "held_valid");
    checkWord("busy_ignore_bits", 32'h0007FFF8, 19);

    clearRx();
    w = WIDTH'($urandom);
    applyStimulus(1'b0, 1'b1, w, 4'd0, "mid_reset");
    idleCycles(6, "mid_reset");
    applyStimulus(1'b1, 1'b0, WIDTH'($urandom), 4'd0, "mid_reset_edge");
    idleCycles(10, "after_reset");
    checkWord("mid_reset_bits", 32'(w) >> 9, 7);
    clearRx();
    w = WIDTH'($urandom);
    applyStimulus(1'b0, 1'b1, w, 4'd0, "post_reset");
    idleCycles(17, "post_reset");
    checkWord("post_reset_bits", 32'(w), 16);

    clearRx();
    applyStimulus(1'b0, 1'b1, 16'h1357, 4'd0, "rst_vs_req_setup");
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 4'd0, "rst_vs_req");
    idleCycles(3, "rst_vs_req");
    checkWord("rst_vs_req_bits", 32'h0, 1);

    for (int k = 0; k < 20; k++) begin
      clearRx();
      w = WIDTH'($urandom);
      m = MOD_W'($urandom_range(3, 15));
      if (k % 5 == 0) m = '0;
      n = specLen(m);
      applyStimulus(1'b0, 1'b1, w, m, "rand_word");
      idleCycles(n + 1, "rand_word");
      checkWord("rand_word_bits", 32'(w) >> (WIDTH - n), n);
    end

    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(0, 49) == 0), 1'($urandom), WIDTH'($urandom),
                    MOD_W'($urandom), "random_mix");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
